// File: rtl/bcd_7seg_scan.sv
// rtl/bcd_7seg_scan.sv - multiplexed 7-segment scan driver with blanking, DP and scan strobes
module bcd_7seg_scan #(
  parameter int N_DIG    = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GAP      = 1,
  parameter bit SEG_AL   = 1'b1,
  parameter bit AN_AL    = 1'b1
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               ce_i,
  input  logic               ld_i,
  input  logic [4*N_DIG-1:0] d_i,
  input  logic [N_DIG-1:0]   dp_i,
  input  logic               lzb_i,
  output logic [6:0]         seg_o,
  output logic               dp_o,
  output logic [N_DIG-1:0]   an_o,
  output logic               tick_o,
  output logic               frame_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GAP_END    = PW'(GAP);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);

  // Levels that mean "off" at the pins, used at reset and when blanking.
  localparam logic [6:0]       SEG_OFF = SEG_AL ? 7'h7F : 7'h00;
  localparam logic             DP_OFF  = SEG_AL;
  localparam logic [N_DIG-1:0] AN_OFF  = AN_AL ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [N_DIG-1:0][3:0]   dig_q, dig_d;
  logic [N_DIG-1:0]        dpr_q, dpr_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [N_DIG-1:0]        an_q, an_d;
  logic                    tick_q, tick_d;
  logic                    frame_q, frame_d;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h40;
    endcase
  endfunction

  logic [N_DIG-1:0] zero_up;   // zero_up[i]: digit i and every higher digit are 4'h0
  logic             blank;
  logic             dp_cur;
  logic             in_gap;
  logic             wrap;
  logic [6:0]       seg_raw;
  logic [N_DIG-1:0] an_raw;

  // Leading-zero chain, current-digit decode and the next registered outputs.
  always_comb begin
    zero_up = '0;
    zero_up[N_DIG-1] = (dig_q[N_DIG-1] == 4'h0);
    for (int i = N_DIG - 2; i >= 0; i--) begin
      zero_up[i] = zero_up[i+1] && (dig_q[i] == 4'h0);
    end
    blank   = lzb_i && (idx_q != '0) && zero_up[idx_q];
    dp_cur  = dpr_q[idx_q];
    in_gap  = (presc_q < GAP_END);
    seg_raw = blank ? 7'h00 : bcd_to_seg(dig_q[idx_q]);
    // A blanked digit still gets its anode if its decimal point must show.
    an_raw  = (!in_gap && (!blank || dp_cur)) ? (N_DIG'(1) << idx_q) : '0;
    seg_d   = SEG_AL ? ~seg_raw : seg_raw;
    dp_d    = SEG_AL ? ~dp_cur : dp_cur;
    an_d    = AN_AL ? ~an_raw : an_raw;
  end

  // Prescaler, digit index, scan strobes and display-register load.
  always_comb begin
    wrap    = ce_i && (presc_q == PRESC_LAST);
    presc_d = presc_q;
    idx_d   = idx_q;
    if (ce_i) begin
      presc_d = wrap ? '0 : presc_q + PW'(1);
    end
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    tick_d  = wrap;
    frame_d = wrap && (idx_q == IDX_LAST);
    dig_d   = ld_i ? d_i : dig_q;
    dpr_d   = ld_i ? dp_i : dpr_q;
  end

  // State and output registers; clear wins over load and scan enable.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      presc_q <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      dpr_q   <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dpr_q   <= dpr_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign tick_o  = tick_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// tb/tb_bcd_7seg_scan.sv - scoreboard bench for bcd_7seg_scan with a behavioural display model
module tb_bcd_7seg_scan;

  localparam int N = 4;
  localparam int DIV = 4;
  localparam int GAPC = 1;

  logic         clk = 1'b0;
  logic         clr, ce, ld, lzb;
  logic [15:0]  d;
  logic [3:0]   dp;
  logic [6:0]   seg;
  logic         dpo;
  logic [3:0]   an;
  logic         tick, frame;

  bcd_7seg_scan #(.N_DIG(N), .SCAN_DIV(DIV), .GAP(GAPC), .SEG_AL(1'b1), .AN_AL(1'b1)) dut (
    .clk_i(clk), .clr_i(clr), .ce_i(ce), .ld_i(ld), .d_i(d), .dp_i(dp), .lzb_i(lzb),
    .seg_o(seg), .dp_o(dpo), .an_o(an), .tick_o(tick), .frame_o(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
    logic       frame;
  } out_t;

  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: what is on the display, where the scan is, plain integers.
  int   m_presc = 0;
  int   m_idx = 0;
  int   m_val = 0;        // latched 16-bit number, digit i = nibble i
  bit   m_dp[N];
  logic [6:0] lit_tbl[16];

  initial begin
    lit_tbl[0] = 7'h3F; lit_tbl[1] = 7'h06; lit_tbl[2] = 7'h5B; lit_tbl[3] = 7'h4F;
    lit_tbl[4] = 7'h66; lit_tbl[5] = 7'h6D; lit_tbl[6] = 7'h7D; lit_tbl[7] = 7'h07;
    lit_tbl[8] = 7'h7F; lit_tbl[9] = 7'h6F;
    for (int k = 10; k < 16; k++) lit_tbl[k] = 7'h40;
    for (int k = 0; k < N; k++) m_dp[k] = 1'b0;
  end

  function automatic out_t model_out(input bit c, input bit e, input bit z);
    out_t o;
    int   digit;
    bit   blanked, dpon, lit_an;
    if (c) begin
      o.seg = 7'h7F; o.dp = 1'b1; o.an = 4'hF; o.tick = 1'b0; o.frame = 1'b0;
      return o;
    end
    digit   = (m_val / (16 ** m_idx)) % 16;
    blanked = z && (m_idx > 0) && ((m_val / (16 ** m_idx)) == 0);
    dpon    = m_dp[m_idx];
    o.seg   = blanked ? 7'h7F : ~lit_tbl[digit];
    o.dp    = ~dpon;
    lit_an  = (m_presc >= GAPC) && (!blanked || dpon);
    o.an    = 4'hF;
    if (lit_an) o.an[m_idx] = 1'b0;
    o.tick  = e && (m_presc == DIV - 1);
    o.frame = o.tick && (m_idx == N - 1);
    return o;
  endfunction

  task automatic step(input bit c, input bit e, input bit l, input logic [15:0] dv,
                      input logic [3:0] dpv, input bit z);
    clr = c; ce = e; ld = l; d = dv; dp = dpv; lzb = z;
    exp_q.push_back(model_out(c, e, z));
    @(posedge clk);
    if (c) begin
      m_presc = 0; m_idx = 0; m_val = 0;
      for (int k = 0; k < N; k++) m_dp[k] = 1'b0;
    end else begin
      if (l) begin
        m_val = int'(dv);
        for (int k = 0; k < N; k++) m_dp[k] = dpv[k];
      end
      if (e) begin
        if (m_presc == DIV - 1) begin
          m_presc = 0;
          m_idx = (m_idx + 1) % N;
        end else begin
          m_presc++;
        end
      end
    end
    #1;
  endtask

  // Monitor: each cycle the DUT presents a new registered output word.
  initial begin
    out_t ex;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        n_cmp++;
        if ({seg, dpo, an, tick, frame} !== ex) begin
          n_err++;
          $display("FAIL scoreboard t=%0t seg=%h dp=%b an=%h tick=%b frame=%b expected seg=%h dp=%b an=%h tick=%b frame=%b",
                   $time, seg, dpo, an, tick, frame, ex.seg, ex.dp, ex.an, ex.tick, ex.frame);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  logic [3:0] an_ref[16];
  logic [6:0] seg_ref[16];
  int         n_tick, n_frame, wait_cyc;
  logic [15:0] rd;

  initial begin
    clr = 1'b1; ce = 1'b0; ld = 1'b0; d = '0; dp = '0; lzb = 1'b0;
    step(1, 0, 0, 16'h0, 4'h0, 0);
    step(1, 1, 1, 16'h9999, 4'hF, 0);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dpo, 1);
    chk("reset_tick_frame", {tick, frame}, 0);

    // Plain scan of 1234, compared against literal slot patterns.
    an_ref  = '{4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7,4'hF};
    seg_ref = '{7'h19,7'h19,7'h19,7'h30,7'h30,7'h30,7'h30,7'h24,7'h24,7'h24,7'h24,7'h79,7'h79,7'h79,7'h79,7'h19};
    step(0, 1, 1, 16'h1234, 4'h0, 0);
    chk("first_gap_an", an, 4'hF);
    n_tick = 0; n_frame = 0;
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 0, 16'h0, 4'h0, 0);
      chk($sformatf("scan_an_%0d", k), an, an_ref[k]);
      chk($sformatf("scan_seg_%0d", k), seg, seg_ref[k]);
      n_tick += tick; n_frame += frame;
    end
    chk("tick_count", n_tick, 4);
    chk("frame_count", n_frame, 1);

    // Blanking cases: 0070, 0000, 00A0 with DP on digit 2.
    step(0, 1, 1, 16'h0070, 4'h0, 1);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 16'h0, 4'h0, 1);
    step(0, 1, 1, 16'h0000, 4'h0, 1);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 16'h0, 4'h0, 1);
    step(0, 1, 1, 16'h00A0, 4'b0100, 1);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 16'h0, 4'h0, 1);

    // Freeze with CE low, then load mid-slot.
    step(0, 1, 1, 16'h5678, 4'b0011, 0);
    step(0, 1, 0, 16'h0, 4'h0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 16'h0, 4'h0, 0);
    step(0, 1, 1, 16'h9A0B, 4'b1000, 0);
    for (int k = 0; k < 12; k++) step(0, 1, 0, 16'h0, 4'h0, 0);

    // Clear in mid-scan.
    wait_cyc = 0;
    while (m_idx != 2 && wait_cyc < 40) begin
      step(0, 1, 0, 16'h0, 4'h0, 0);
      wait_cyc++;
    end
    chk("reach_idx2", m_idx, 2);
    step(1, 1, 1, 16'h4321, 4'hF, 0);
    chk("midclr_an", an, 4'hF);
    chk("midclr_seg", seg, 7'h7F);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 16'h0, 4'h0, 0);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      for (int j = 0; j < N; j++) rd[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           rd, 4'($urandom_range(0, 15)), ((k / 200) % 2 == 0));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
